dmem_lsu_port: RTL and testbench
================================

DMEM_LSU_PORT -- requirements
Module: dmem_lsu_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address bits; depth = 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter RD_LAT, default 1, legal 1..4, cycles from read accept to read response.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rset  input  1  synchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request may be accepted this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  ADDR_W+2  byte address.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-010 SHALL have port req_unsigned  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-011 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse, no back-pressure.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned or reserved-size request.

Function
REQ-015 SHALL accept a request on a rising edge where rset=1, req_valid=1 and req_ready=1.
REQ-016 SHALL implement FSM states IDLE and WAIT; req_ready = 1 only in IDLE with rset=1.
REQ-017 SHALL flag error when size=01 and addr[0]=1, size=10 and addr[1:0]!=00, or size=11.
REQ-018 SHALL, for an error request, leave memory unchanged and pulse rsp_valid with rsp_err=1 and rsp_rdata=0 the cycle after accept; FSM stays IDLE.
REQ-019 SHALL, for a legal store, write at the accept edge to word addr[ADDR_W+1:2], little-endian: byte -> lane addr[1:0] from wdata[7:0], half -> lanes {addr[1],0..1} from wdata[15:0], word -> all lanes; other lanes unchanged.
REQ-020 SHALL pulse rsp_valid (err=0, rdata=0) the cycle after a store accept; FSM stays IDLE, so stores sustain one per cycle.
REQ-021 SHALL, for a legal load with RD_LAT=1, stay IDLE and pulse rsp_valid the cycle after accept.
REQ-022 SHALL, for a legal load with RD_LAT>1, enter WAIT with down-counter loaded to RD_LAT-2, hold req_ready=0, return to IDLE when counter is 0, and pulse rsp_valid exactly RD_LAT cycles after accept; req_ready reasserts in the rsp_valid cycle.
REQ-023 SHALL select load lane/half per addr[1:0] and sign- or zero-extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-024 SHALL return load data as of the accept edge (latched at accept), unaffected by later stores.
REQ-025 SHALL ignore req_* inputs whenever req_ready=0 and never queue more than one load.
REQ-026 SHALL hold rsp_rdata and rsp_err at 0 in every cycle rsp_valid=0.
REQ-027 SHALL treat req_addr above ADDR_W+2 bits as nonexistent (no wrap logic needed; width-limited).

Reset
REQ-028 SHALL, while rset=0 at an edge, force FSM=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and block acceptance (req_ready=0).
REQ-029 SHALL discard any in-flight load on reset; no rsp_valid for it after rset returns to 1.
REQ-030 SHALL NOT clear memory contents on reset; contents persist across reset.

Verification
REQ-031 Store word 0x8000_00F1 to 0x10, load byte 0x10 signed -> rsp_rdata 0xFFFF_FFF1; unsigned -> 0x0000_00F1.
REQ-032 Store byte 0xAB to 0x13 over word 0x1122_3344 at 0x10, load word 0x10 -> 0xAB22_3344.
REQ-033 Load half at 0x11 -> rsp_err=1, rsp_rdata=0, memory unchanged; size=11 at 0x10 -> rsp_err=1.
REQ-034 RD_LAT=3: load accepted at edge k -> req_ready=0 cycles k+1..k+2, rsp_valid only in cycle k+3, req_ready=1 in k+3.
REQ-035 RD_LAT=3: rset=0 one cycle after load accept -> no rsp_valid ever for that load; prior stored data still readable after reset.
REQ-036 Back-to-back stores to 0x00,0x04,0x08 on consecutive cycles -> three consecutive rsp_valid pulses, all three words written.

Source files
------------

// File: rtl/dmem_lsu_port.sv
// Single-port 32-bit data memory behind a load/store request port.
// Byte, half and word accesses with sign or zero extension, and a configurable read latency.
module dmem_lsu_port #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic [31:0] r_ldata, w_ldata_nxt;
  logic [31:0] r_mem [DEPTH];

  logic              w_acc;
  logic              w_err;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_widx;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_lext;
  logic [3:0]        w_be;
  logic [31:0]       w_wlane;

  assign req_ready = rset && (r_state == IDLE);
  assign w_acc     = req_valid && req_ready;
  assign w_widx    = req_addr[ADDR_W+1:2];
  assign w_word    = r_mem[w_widx];
  assign w_byte    = w_word[{req_addr[1:0], 3'b000} +: 8];
  assign w_half    = req_addr[1] ? w_word[31:16] : w_word[15:0];

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_comb begin
    w_err   = 1'b0;
    w_lext  = w_word;
    w_be    = 4'b1111;
    w_wlane = req_wdata;
    case (req_size)
      2'b00: begin
        w_lext  = req_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_be    = 4'b0001 << req_addr[1:0];
        w_wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_err   = req_addr[0];
        w_lext  = req_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{req_wdata[15:0]}};
      end
      2'b10:   w_err = (req_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
  end

  // Stores and error requests complete without leaving IDLE; only slow loads visit WAIT.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = 32'd0;
    w_rsp_err_nxt   = 1'b0;
    w_ldata_nxt     = r_ldata;
    w_mem_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_err) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else if (req_we) begin
            w_mem_we        = 1'b1;
            w_rsp_valid_nxt = 1'b1;
          end else if (RD_LAT == 1) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = w_lext;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
            w_ldata_nxt = w_lext;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_ldata;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rset) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_ldata     <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_ldata     <= w_ldata_nxt;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_port.sv
// Scoreboard bench for dmem_lsu_port with RD_LAT=3: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever rsp_valid is seen.
module tb_dmem_lsu_port;

  localparam int ADDR_W = 8;
  localparam int RD_LAT = 3;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

  logic              clk;
  logic              rset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W+1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   runLen = 0;
  int   maxRun = 0;

  dmem_lsu_port #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rset        (rset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [ADDR_W+1:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr, input logic expectRsp);
    int waited;
    rsp_t r;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 32'(req_ready), 32'd1);
    end else if (expectRsp) begin
      r.rdata = expData;
      r.err   = expErr;
      expQ.push_back(r);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare each response against the scoreboard; quiet cycles must be all-zero.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      runLen++;
      if (runLen > maxRun) maxRun = runLen;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end else begin
      runLen = 0;
      if (rset === 1'b1) begin
        checkOutput("idle_rdata", rsp_rdata, 32'd0);
        checkOutput("idle_err", 32'(rsp_err), 32'd0);
      end
    end
  end

  initial begin
    rset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = SZ_W; req_unsigned = 1'b0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rdata", rsp_rdata, 32'd0);
    rset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

    // Extension of a negative byte
    applyStimulus(1, 10'h010, SZ_W, 0, 32'h8000_00F1, 32'd0, 0, 1);
    applyStimulus(0, 10'h010, SZ_B, 0, 32'd0, 32'hFFFF_FFF1, 0, 1);
    applyStimulus(0, 10'h010, SZ_B, 1, 32'd0, 32'h0000_00F1, 0, 1);

    // Byte store merges into existing word
    applyStimulus(1, 10'h010, SZ_W, 0, 32'h1122_3344, 32'd0, 0, 1);
    applyStimulus(1, 10'h013, SZ_B, 0, 32'h0000_00AB, 32'd0, 0, 1);
    applyStimulus(0, 10'h010, SZ_W, 0, 32'd0, 32'hAB22_3344, 0, 1);

    // Error requests leave memory alone
    applyStimulus(0, 10'h011, SZ_H, 0, 32'd0, 32'd0, 1, 1);
    applyStimulus(1, 10'h011, SZ_H, 0, 32'h0000_FFFF, 32'd0, 1, 1);
    applyStimulus(0, 10'h010, SZ_R, 0, 32'd0, 32'd0, 1, 1);
    applyStimulus(1, 10'h010, SZ_R, 0, 32'hFFFF_FFFF, 32'd0, 1, 1);
    applyStimulus(0, 10'h012, SZ_W, 0, 32'd0, 32'd0, 1, 1);
    applyStimulus(0, 10'h010, SZ_W, 0, 32'd0, 32'hAB22_3344, 0, 1);

    // Lane selection and extension
    applyStimulus(0, 10'h012, SZ_H, 0, 32'd0, 32'hFFFF_AB22, 0, 1);
    applyStimulus(0, 10'h012, SZ_H, 1, 32'd0, 32'h0000_AB22, 0, 1);
    applyStimulus(0, 10'h011, SZ_B, 0, 32'd0, 32'h0000_0033, 0, 1);
    applyStimulus(0, 10'h013, SZ_B, 0, 32'd0, 32'hFFFF_FFAB, 0, 1);
    applyStimulus(0, 10'h010, SZ_H, 1, 32'd0, 32'h0000_3344, 0, 1);
    applyStimulus(0, 10'h013, SZ_W, 1, 32'd0, 32'd0, 1, 1);

    // Upper half store
    applyStimulus(1, 10'h014, SZ_W, 0, 32'h0000_0000, 32'd0, 0, 1);
    applyStimulus(1, 10'h016, SZ_H, 0, 32'h1234_BEEF, 32'd0, 0, 1);
    applyStimulus(0, 10'h014, SZ_W, 0, 32'd0, 32'hBEEF_0000, 0, 1);
    applyStimulus(0, 10'h015, SZ_B, 0, 32'd0, 32'd0, 0, 1);

    // Latency profile; a store offered during WAIT must be ignored
    applyStimulus(0, 10'h010, SZ_W, 0, 32'd0, 32'hAB22_3344, 0, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h010; req_size = SZ_W; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("lat_k1_ready", 32'(req_ready), 32'd0);
    checkOutput("lat_k1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_k2_ready", 32'(req_ready), 32'd0);
    checkOutput("lat_k2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_k3_ready", 32'(req_ready), 32'd1);
    checkOutput("lat_k3_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    applyStimulus(0, 10'h010, SZ_W, 0, 32'd0, 32'hAB22_3344, 0, 1);

    // Back-to-back stores
    idleCycles(5);
    maxRun = 0;
    applyStimulus(1, 10'h000, SZ_W, 0, 32'h0101_0101, 32'd0, 0, 1);
    applyStimulus(1, 10'h004, SZ_W, 0, 32'h0202_0202, 32'd0, 0, 1);
    applyStimulus(1, 10'h008, SZ_W, 0, 32'h0303_0303, 32'd0, 0, 1);
    idleCycles(3);
    checkOutput("b2b_consecutive", 32'(maxRun), 32'd3);
    applyStimulus(0, 10'h000, SZ_W, 0, 32'd0, 32'h0101_0101, 0, 1);
    applyStimulus(0, 10'h004, SZ_W, 0, 32'd0, 32'h0202_0202, 0, 1);
    applyStimulus(0, 10'h008, SZ_W, 0, 32'd0, 32'h0303_0303, 0, 1);

    // Reset one cycle after a load accept drops the load; memory survives
    applyStimulus(0, 10'h004, SZ_W, 0, 32'd0, 32'd0, 0, 0);
    @(negedge clk);
    rset = 1'b0;
    #1 checkOutput("rst_blocks_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rset = 1'b1;
    idleCycles(6);
    applyStimulus(0, 10'h004, SZ_W, 0, 32'd0, 32'h0202_0202, 0, 1);
    applyStimulus(0, 10'h010, SZ_W, 0, 32'd0, 32'hAB22_3344, 0, 1);

    idleCycles(6);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
